// File: rtl/fifoc2cs_gen_if.sv
// Command-FIFO decoder bus: control-section handshake, FIFO read port and
// committed command registers. The slave modport is the decoder's view.
interface fifoc2cs_gen_if #(
    parameter int NUM_REG = 9,
    parameter int LEN_W   = 12
);
    logic                   fs;
    logic                   fd;
    logic [LEN_W-1:0]       rx_len;
    logic                   fifoc_rxen;
    logic [7:0]             fifoc_rxd;
    logic [NUM_REG*8-1:0]   cmd_regs;
    logic                   cmd_vld;
    logic [1:0]             err;

    modport master (
        output fs, rx_len, fifoc_rxd,
        input  fd, fifoc_rxen, cmd_regs, cmd_vld, err
    );

    modport slave (
        input  fs, rx_len, fifoc_rxd,
        output fd, fifoc_rxen, cmd_regs, cmd_vld, err
    );
endinterface

// File: rtl/fifoc2cs_gen.sv
// fifoc2cs_gen: drains one command frame from the command FIFO, validates it and
// commits NUM_REG bytes atomically. Define FIFOC2CS_CKSUM_EN for a trailing XOR checksum.

module fifoc2cs_gen_chk (
    input logic       clk,
    input logic       rst,
    input logic       fd,
    input logic       rxen,
    input logic       cmd_vld,
    input logic [1:0] err
);
    a_vld_in_done: assert property (@(posedge clk) disable iff (!rst) cmd_vld |-> fd);
    a_vld_is_ok:   assert property (@(posedge clk) disable iff (!rst) cmd_vld |-> (err == 2'd0));
    a_rxen_idle:   assert property (@(posedge clk) disable iff (!rst) !(rxen && fd));
`ifndef FIFOC2CS_CKSUM_EN
    a_no_sum_err:  assert property (@(posedge clk) disable iff (!rst) err != 2'd3);
`endif
endmodule

module fifoc2cs_gen #(
    parameter int         NUM_REG = 9,
    parameter logic [7:0] HEAD0   = 8'h55,
    parameter logic [7:0] HEAD1   = 8'hAA,
    parameter int         LEN_W   = 12
) (
    input  logic          clk,
    input  logic          rst,
    fifoc2cs_gen_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

`ifdef FIFOC2CS_CKSUM_EN
    localparam int CKSUM_BYTES = 1;
`else
    localparam int CKSUM_BYTES = 0;
`endif
    localparam int               FRAME_LEN   = NUM_REG + 2 + CKSUM_BYTES;
    localparam logic [LEN_W-1:0] FRAME_LEN_L = LEN_W'(FRAME_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);
    localparam logic [LEN_W-1:0] IDX_HEAD0   = LEN_W'(0);
    localparam logic [LEN_W-1:0] IDX_HEAD1   = LEN_W'(1);

    state_t               r_state;
    state_t               w_next;
    logic [LEN_W-1:0]     r_len_q;
    logic [LEN_W-1:0]     r_rd_cnt;
    logic [LEN_W-1:0]     r_wr_idx;
    logic                 r_cap;
    logic [NUM_REG*8-1:0] r_shadow;
    logic                 r_hdr_bad;
    logic                 r_fd;
    logic                 r_rxen;
    logic                 r_cmd_vld;
    logic [NUM_REG*8-1:0] r_cmd_regs;
    logic [1:0]           r_err;
    logic                 w_start;
    logic                 w_sum_bad;
    logic                 w_commit;
    logic                 w_fd_nxt;
    logic                 w_rxen_nxt;
    logic [1:0]           w_err_code;
    logic [7:0]           w_byte;

    // Error priority: length beats header beats checksum.
    function automatic logic [1:0] f_err_code(input logic len_bad, input logic hdr_bad,
                                              input logic sum_bad);
        logic [1:0] code;
        if (len_bad) begin
            code = 2'd2;
        end else if (hdr_bad) begin
            code = 2'd1;
        end else if (sum_bad) begin
            code = 2'd3;
        end else begin
            code = 2'd0;
        end
        return code;
    endfunction

    assign w_start = (r_state == S_IDLE) && bus.fs;
    assign w_byte  = bus.fifoc_rxd;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!bus.fs) begin
                    w_next = S_IDLE;
                end else if (bus.rx_len == '0) begin
                    w_next = S_CHECK;
                end else begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                if (r_rd_cnt == (r_len_q - LEN_ONE)) begin
                    w_next = S_WAIT;
                end else begin
                    w_next = S_READ;
                end
            end
            S_WAIT:  w_next = S_CHECK;
            S_CHECK: w_next = S_DONE;
            S_DONE: begin
                if (bus.fs) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode: next values of the registered outputs.
    always_comb begin
        w_rxen_nxt = (w_next == S_READ);
        w_fd_nxt   = (w_next == S_DONE);
        w_err_code = f_err_code(r_len_q != FRAME_LEN_L, r_hdr_bad, w_sum_bad);
        w_commit   = (r_state == S_CHECK) && (w_err_code == 2'd0);
    end

    // Output registers; cmd_regs only ever change as a whole on a clean frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fd       <= 1'b0;
            r_rxen     <= 1'b0;
            r_cmd_vld  <= 1'b0;
            r_cmd_regs <= '0;
            r_err      <= 2'd0;
        end else begin
            r_fd      <= w_fd_nxt;
            r_rxen    <= w_rxen_nxt;
            r_cmd_vld <= w_commit;
            if (w_commit) begin
                r_cmd_regs <= r_shadow;
            end else begin
                r_cmd_regs <= r_cmd_regs;
            end
            if (w_start) begin
                r_err <= 2'd0;
            end else if (r_state == S_CHECK) begin
                r_err <= w_err_code;
            end else begin
                r_err <= r_err;
            end
        end
    end

    // Frame length latch and read-enable counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len_q  <= '0;
            r_rd_cnt <= '0;
        end else if (w_start) begin
            r_len_q  <= bus.rx_len;
            r_rd_cnt <= '0;
        end else if (r_state == S_READ) begin
            r_rd_cnt <= r_rd_cnt + LEN_ONE;
        end else begin
            r_rd_cnt <= r_rd_cnt;
        end
    end

    // Byte capture one cycle behind the read enable, with header check.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cap     <= 1'b0;
            r_wr_idx  <= '0;
            r_hdr_bad <= 1'b0;
        end else begin
            r_cap <= r_rxen;
            if (w_start) begin
                r_wr_idx  <= '0;
                r_hdr_bad <= 1'b0;
            end else if (r_cap) begin
                r_wr_idx <= r_wr_idx + LEN_ONE;
                if (((r_wr_idx == IDX_HEAD0) && (w_byte != HEAD0)) ||
                    ((r_wr_idx == IDX_HEAD1) && (w_byte != HEAD1))) begin
                    r_hdr_bad <= 1'b1;
                end else begin
                    r_hdr_bad <= r_hdr_bad;
                end
            end else begin
                r_wr_idx <= r_wr_idx;
            end
        end
    end

    // Shadow payload; bytes past the payload window are read and dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow <= '0;
        end else if (w_start) begin
            r_shadow <= '0;
        end else if (r_cap) begin
            for (int k = 0; k < NUM_REG; k++) begin
                if (r_wr_idx == LEN_W'(k + 2)) begin
                    r_shadow[8*k +: 8] <= w_byte;
                end
            end
        end else begin
            r_shadow <= r_shadow;
        end
    end

`ifdef FIFOC2CS_CKSUM_EN
    localparam logic [LEN_W-1:0] IDX_PAY0 = LEN_W'(2);
    localparam logic [LEN_W-1:0] IDX_CSUM = LEN_W'(NUM_REG + 2);

    logic [7:0] r_csum;
    logic       r_sum_bad;

    // Running XOR of the payload, compared against the trailing byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_csum    <= 8'h00;
            r_sum_bad <= 1'b0;
        end else if (w_start) begin
            r_csum    <= 8'h00;
            r_sum_bad <= 1'b0;
        end else if (r_cap && (r_wr_idx >= IDX_PAY0) && (r_wr_idx < IDX_CSUM)) begin
            r_csum <= r_csum ^ w_byte;
        end else if (r_cap && (r_wr_idx == IDX_CSUM)) begin
            r_sum_bad <= (w_byte != r_csum);
        end else begin
            r_csum <= r_csum;
        end
    end

    assign w_sum_bad = r_sum_bad;
`else
    assign w_sum_bad = 1'b0;
`endif

    assign bus.fd         = r_fd;
    assign bus.fifoc_rxen = r_rxen;
    assign bus.cmd_regs   = r_cmd_regs;
    assign bus.cmd_vld    = r_cmd_vld;
    assign bus.err        = r_err;

    fifoc2cs_gen_chk u_chk (
        .clk     (clk),
        .rst     (rst),
        .fd      (r_fd),
        .rxen    (r_rxen),
        .cmd_vld (r_cmd_vld),
        .err     (r_err)
    );

endmodule

// File: tb/tb_fifoc2cs_gen.sv
// Scoreboard bench for fifoc2cs_gen: a driver issues frames and queues the
// expected outcome from a frame-level model; a monitor checks each fd rise.
module tb_fifoc2cs_gen;
    localparam int NUM_REG = 9;
    localparam int LEN_W   = 12;
`ifdef FIFOC2CS_CKSUM_EN
    localparam int CKV = 1;
`else
    localparam int CKV = 0;
`endif
    localparam int FL = NUM_REG + 2 + CKV;
    localparam int RW = NUM_REG * 8;

    typedef struct {
        logic [1:0]    err;
        logic [RW-1:0] regs;
        int            vld;
        int            nrd;
        int            lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fifoc2cs_gen_if #(.NUM_REG(NUM_REG), .LEN_W(LEN_W)) bus ();

    fifoc2cs_gen #(.NUM_REG(NUM_REG), .HEAD0(8'h55), .HEAD1(8'hAA), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            start_cyc = 0;
    logic [7:0]    fifo_mem [0:8191];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    int            underflow = 0;
    logic [7:0]    frame_q [$];
    exp_t          exp_q [$];
    logic [RW-1:0] m_regs;
    int            mon_vld = 0;
    int            mon_rd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Command FIFO: data appears the cycle after the read enable; reset empties it.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.fifoc_rxd <= 8'h00;
            rd_ptr = wr_ptr;
        end else if (bus.fifoc_rxen) begin
            if (rd_ptr != wr_ptr) begin
                bus.fifoc_rxd <= fifo_mem[rd_ptr % 8192];
                rd_ptr = rd_ptr + 1;
            end else begin
                bus.fifoc_rxd <= 8'hEE;
                underflow = underflow + 1;
            end
        end
    end

    // Frame-level reference: whole-frame rules, previous committed value kept on error.
    function automatic exp_t model(input int len);
        exp_t e;
        logic [7:0] x;
        e.err = 2'd0;
        e.vld = 0;
        e.nrd = len;
        e.lat = (len == 0) ? 2 : len + 3;
        if (len != FL) begin
            e.err = 2'd2;
        end else if (frame_q[0] != 8'h55 || frame_q[1] != 8'hAA) begin
            e.err = 2'd1;
        end else begin
            x = 8'h00;
            for (int i = 0; i < NUM_REG; i++) x = x ^ frame_q[2 + i];
            if (CKV == 1 && frame_q[NUM_REG + 2] != x) e.err = 2'd3;
        end
        if (e.err == 2'd0) begin
            for (int i = 0; i < NUM_REG; i++) m_regs[8*i +: 8] = frame_q[2 + i];
            e.vld = 1;
        end
        e.regs = m_regs;
        return e;
    endfunction

    // cmode: 0 good checksum, 1 forced 0x00, 2 corrupted.
    task automatic mk_frame(input logic [7:0] h0, input logic [7:0] h1, input bit seq,
                            input int cmode, input int len);
        logic [7:0] all [$];
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        all.push_back(h0);
        all.push_back(h1);
        for (int i = 0; i < NUM_REG; i++) begin
            b = seq ? 8'(i + 1) : 8'($urandom);
            all.push_back(b);
            x = x ^ b;
        end
        if (CKV == 1) begin
            if (cmode == 1) all.push_back(8'h00);
            else if (cmode == 2) all.push_back(x ^ 8'($urandom_range(1, 255)));
            else all.push_back(x);
        end
        while (all.size() < len) all.push_back(8'($urandom));
        frame_q.delete();
        for (int i = 0; i < len; i++) frame_q.push_back(all[i]);
    endtask

    task automatic push_fifo(input int len);
        for (int i = 0; i < len; i++) begin
            fifo_mem[wr_ptr % 8192] = frame_q[i];
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic run_frame(input int len, input int hold, input bit early);
        int t;
        int fd_hi;
        push_fifo(len);
        exp_q.push_back(model(len));
        @(posedge clk); #1;
        start_cyc = cyc;
        bus.fs = 1'b1;
        bus.rx_len = LEN_W'(len);
        @(posedge clk); #1;
        bus.rx_len = LEN_W'($urandom);
        if (early) bus.fs = 1'b0;
        t = 0;
        while (!bus.fd && t < len + 20) begin
            @(negedge clk);
            t++;
        end
        check("fd_rise", bus.fd, 1);
        fd_hi = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.fd) fd_hi++;
        end
        if (hold > 0) check("fd_hold", fd_hi, hold);
        @(posedge clk); #1;
        bus.fs = 1'b0;
        t = 0;
        while (bus.fd && t < 5) begin
            @(negedge clk);
            t++;
        end
        check("fd_fall", bus.fd, 0);
    endtask

    // Monitor: one expected outcome consumed per fd rise.
    initial begin
        exp_t e;
        logic prev_fd;
        prev_fd = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_vld = 0;
                mon_rd  = 0;
                prev_fd = 1'b0;
            end else begin
                if (bus.cmd_vld) mon_vld++;
                if (bus.fifoc_rxen) mon_rd++;
                if (bus.fd && !prev_fd) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("err", bus.err, e.err);
                        check("cmd_regs", bus.cmd_regs, e.regs);
                        check("cmd_vld_pulses", mon_vld, e.vld);
                        check("rxen_cycles", mon_rd, e.nrd);
                        check("latency", cyc - start_cyc, e.lat);
                        check("fifo_drained", wr_ptr - rd_ptr, 0);
                        check("fifo_underflow", underflow, 0);
                    end else begin
                        check("fd_expected", exp_q.size(), 1);
                    end
                    mon_vld = 0;
                    mon_rd  = 0;
                end
                prev_fd = bus.fd;
            end
        end
    end

    initial begin
        bus.fs = 1'b0;
        bus.rx_len = '0;
        m_regs = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fd", bus.fd, 0);
        check("rst_rxen", bus.fifoc_rxen, 0);
        check("rst_cmd_regs", bus.cmd_regs, 0);
        check("rst_cmd_vld", bus.cmd_vld, 0);
        check("rst_err", bus.err, 0);
        rst = 1'b1;

        mk_frame(8'h55, 8'hAA, 1'b1, 0, FL);     run_frame(FL, 1, 1'b0);
        mk_frame(8'h55, 8'hAB, 1'b1, 0, FL);     run_frame(FL, 0, 1'b0);
        mk_frame(8'h55, 8'hAA, 1'b1, 1, FL);     run_frame(FL, 2, 1'b0);
        mk_frame(8'h55, 8'hAA, 1'b0, 0, FL);     run_frame(FL, 0, 1'b0);
        mk_frame(8'h55, 8'hAA, 1'b1, 0, FL + 2); run_frame(FL + 2, 0, 1'b0);
        mk_frame(8'h55, 8'hAA, 1'b1, 0, 0);      run_frame(0, 0, 1'b0);
        mk_frame(8'h55, 8'hAA, 1'b1, 0, 5);      run_frame(5, 0, 1'b1);
        mk_frame(8'h55, 8'hAA, 1'b0, 0, FL);     run_frame(FL, 0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            int sel;
            int len;
            int cm;
            logic [7:0] h0;
            logic [7:0] h1;
            bit early;
            sel = $urandom_range(0, 9);
            case (sel)
                6:       len = 0;
                7:       len = $urandom_range(1, FL - 1);
                8:       len = FL + $urandom_range(1, 4);
                9:       len = $urandom_range(0, 30);
                default: len = FL;
            endcase
            h0 = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h55;
            h1 = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hAA;
            cm = ($urandom_range(0, 4) == 0) ? 2 : 0;
            early = ($urandom_range(0, 5) == 0);
            mk_frame(h0, h1, 1'b0, cm, len);
            run_frame(len, early ? 0 : $urandom_range(0, 3), early);
        end

        mk_frame(8'h55, 8'hAA, 1'b0, 0, FL);
        run_frame(FL, 0, 1'b0);

        // Reset on the 5th read cycle of an otherwise valid frame.
        mk_frame(8'h55, 8'hAA, 1'b0, 0, FL);
        push_fifo(FL);
        @(posedge clk); #1;
        bus.fs = 1'b1;
        bus.rx_len = LEN_W'(FL);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_rxen", bus.fifoc_rxen, 0);
        check("abort_fd", bus.fd, 0);
        check("abort_cmd_regs", bus.cmd_regs, 0);
        check("abort_cmd_vld", bus.cmd_vld, 0);
        check("abort_err", bus.err, 0);
        bus.fs = 1'b0;
        m_regs = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        check("abort_fifo_flushed", wr_ptr - rd_ptr, 0);

        mk_frame(8'h55, 8'hAA, 1'b1, 0, FL);
        run_frame(FL, 10, 1'b0);

        repeat (5) @(negedge clk);
        check("exp_queue_empty", exp_q.size(), 0);
        check("stray_cmd_vld", mon_vld, 0);
        check("stray_rxen", mon_rd, 0);
        check("final_underflow", underflow, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifoc2cs_gen.md
Name: fifoc2cs_gen

Overview:
- Parametrised successor to the fixed command-FIFO decoder.
- Drains one command frame of `rx_len` bytes from the command FIFO (read side, system clock domain) on a fs/fd handshake.
- Validates header, length and (optionally) checksum, then commits NUM_REG command bytes atomically to the control section's command registers.
- Reports a 2-bit error code; registers are never partially updated.

Parameters:
- NUM_REG, 9, number of 8-bit command registers carried per frame (1..64).
- HEAD0, 8'h55, first header byte.
- HEAD1, 8'hAA, second header byte.
- LEN_W, 12, width of rx_len.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- fs  in  1  start request from control section; level, held until fd seen.
- fd  out  1  done; high in DONE until fs falls.
- rx_len  in  LEN_W  byte count of frame in FIFO; sampled in IDLE when fs rises.
- fifoc_rxen  out  1  FIFO read enable.
- fifoc_rxd  in  8  FIFO read data, valid exactly one cycle after fifoc_rxen.
- cmd_regs  out  NUM_REG*8  committed registers; byte k at [8k+7:8k], k=0 is first payload byte.
- cmd_vld  out  1  one-cycle pulse when cmd_regs updated.
- err  out  2  0 ok, 1 header, 2 length, 3 checksum; held until next frame starts.

Behaviour:
- Reset values:
  - fd=0, fifoc_rxen=0, cmd_regs=0, cmd_vld=0, err=0.
  - All counters, shadow registers and checksum cleared.
  - State machine in IDLE.
- FRAME_LEN = NUM_REG+3 with checksum, NUM_REG+2 without.
- IDLE:
  - On fs=1, latch rx_len into len_q, clear shadow/checksum/counters/err, and go to READ.
  - If rx_len==0, go directly to CHECK.
- READ:
  - fifoc_rxen=1 for exactly len_q consecutive cycles (rd_cnt counts 0..len_q-1).
  - Data capture uses a 1-cycle delayed enable; byte index wr_idx advances on each captured byte.
  - Byte 0 is compared to HEAD0 and byte 1 to HEAD1; any mismatch sets hdr_bad.
  - Bytes 2..NUM_REG+1 are stored to shadow[idx-2] and XORed into csum.
  - With checksum enabled, byte NUM_REG+2 is compared to csum (mismatch sets sum_bad).
  - Bytes with idx ≥ FRAME_LEN are read and discarded, so the FIFO is always drained by len_q.
  - When rd_cnt reaches len_q-1, deassert rxen and go to WAIT.
- WAIT: one cycle to capture the final byte → CHECK.
- CHECK: error priority is length > header > checksum.
  - If len_q≠FRAME_LEN, err=2.
  - Else if hdr_bad, err=1.
  - Else if sum_bad, err=3.
  - Else err=0, cmd_regs←shadow, and cmd_vld=1 for that single cycle.
  - Then go to DONE.
- DONE: fd=1; when fs=0, drop fd and go to IDLE next cycle.
- Latency: fs high → fd high = len_q+3 cycles (IDLE, len_q READ, WAIT, CHECK); rx_len=0 gives 2.
- Boundaries:
  - rx_len above 4095 cannot occur (width-bounded).
  - Short frame: the missing bytes never update shadow, and err=2.
  - fs dropping mid-READ is ignored; the frame completes.
  - fs still high in DONE keeps fd high; no retrigger until fs=0.
  - Reset asserted mid-frame: immediate return to IDLE with outputs at reset values; cmd_regs reverts to 0.

Optional Feature:
- Macro: FIFOC2CS_CKSUM_EN.
- Defined: frame carries a trailing XOR checksum of the payload bytes, FRAME_LEN=NUM_REG+3, and err=3 is possible.
- Undefined: no checksum byte, FRAME_LEN=NUM_REG+2, csum logic absent, and err=3 is never produced.

Test Plan:
- NUM_REG=9, cksum on; FIFO 55 AA 01..09 01, rx_len=12 → fd after 15 cycles, err=0, cmd_vld one pulse, cmd_regs=72'h090807060504030201.
- Same frame with header 55 AB → err=1, cmd_regs unchanged from previous value, no cmd_vld, 12 reads issued.
- Same frame with checksum byte 0x00 → err=3, cmd_regs unchanged; then a valid frame → err=0, new values committed.
- rx_len=14 (two trailing junk bytes) → 14 rxen cycles, err=2, FIFO empty afterwards; rx_len=0 → no rxen, fd after 2 cycles, err=2.
- rst pulled low on the 5th READ cycle → rxen=0, fd=0, cmd_regs=0 immediately; after release, IDLE accepts a new fs.
- Cksum undefined, frame 55 AA 01..09, rx_len=11 → err=0, committed; hold fs high 10 cycles after fd → fd stays high, a single cmd_vld only.
